// File: rtl/timer_iom.sv
// timer_iom: multi-channel programmable down-counter timer on the MicroBlaze MCS IO bus.
// Define TIMER_IOM_SNAPSHOT_EN to add SNAP (0x108) and per-channel COUNT shadow registers.

module timer_iom_ch #(
   parameter int COUNT_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_tick,
   input  logic                  i_ctrl_we,
   input  logic                  i_load_we,
   input  logic                  i_stat_we,
`ifdef TIMER_IOM_SNAPSHOT_EN
   input  logic                  i_snap,
   output logic [COUNT_BITS-1:0] o_shadow,
`endif
   input  logic [31:0]           i_wdata,
   input  logic [3:0]            i_be,
   output logic [2:0]            o_ctrl,
   output logic [COUNT_BITS-1:0] o_load,
   output logic [COUNT_BITS-1:0] o_count,
   output logic                  o_pend,
   output logic                  o_irq
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t                r_state, w_state_nx;
   logic                  r_per, r_ie, r_pend, r_irq, w_exp, w_ctrl_we, w_w1c;
   logic [COUNT_BITS-1:0] r_load, r_count, w_count_nx;

   assign w_ctrl_we = i_ctrl_we & i_be[0];
   assign w_w1c     = i_stat_we & i_be[0] & i_wdata[0];

   always_comb begin
      w_state_nx = r_state;
      w_count_nx = r_count;
      w_exp      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ctrl_we && i_wdata[0]) begin
               w_state_nx = RUN;
               w_count_nx = r_load;
            end
         end
         RUN: begin
            if (i_tick) begin
               if (r_count != '0) w_count_nx = r_count - 1'b1;
               else begin
                  w_exp = 1'b1;
                  if (r_per) w_count_nx = r_load;
                  else begin
                     w_count_nx = '0;
                     w_state_nx = IDLE;
                  end
               end
            end
            // A CTRL write owns EN even on an expiry cycle; stopping freezes COUNT
            if (w_ctrl_we) begin
               if (!i_wdata[0]) begin
                  w_state_nx = IDLE;
                  w_count_nx = r_count;
               end else begin
                  w_state_nx = RUN;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_load  <= '0;
         r_per   <= 1'b0;
         r_ie    <= 1'b0;
         r_pend  <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_count <= w_count_nx;
         if (w_ctrl_we) begin
            r_per <= i_wdata[1];
            r_ie  <= i_wdata[2];
         end
         if (i_load_we)
            for (int k = 0; k < COUNT_BITS; k++)
               if (i_be[k/8]) r_load[k] <= i_wdata[k];
         if (w_exp)      r_pend <= 1'b1;
         else if (w_w1c) r_pend <= 1'b0;
         r_irq <= r_pend & r_ie;
      end
   end

`ifdef TIMER_IOM_SNAPSHOT_EN
   logic [COUNT_BITS-1:0] r_shadow;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_shadow <= '0;
      else if (i_snap) r_shadow <= r_count;
   end
   assign o_shadow = r_shadow;
`endif

   assign o_ctrl  = {r_ie, r_per, (r_state == RUN)};
   assign o_load  = r_load;
   assign o_count = r_count;
   assign o_pend  = r_pend;
   assign o_irq   = r_irq;
endmodule

module timer_iom #(
   parameter int TIMER_COUNT   = 4,
   parameter int COUNT_BITS    = 32,
   parameter int PRESCALE_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   io_addr_strobe,
   input  logic                   io_read_strobe,
   input  logic                   io_write_strobe,
   input  logic [11:0]            io_address,
   input  logic [3:0]             io_byte_enable,
   input  logic [31:0]            io_write_data,
   output logic [31:0]            io_read_data,
   output logic                   io_ready,
   output logic [TIMER_COUNT-1:0] irq
);
   logic                                   w_wr, w_ch_reg, w_glb, w_pre_we, w_tick;
   logic [PRESCALE_BITS-1:0]               r_pre, r_pcnt;
   logic [TIMER_COUNT-1:0]                 w_ctrl_we, w_load_we, w_stat_we, w_pend, w_irq;
   logic [TIMER_COUNT-1:0][2:0]            w_ctrl;
   logic [TIMER_COUNT-1:0][COUNT_BITS-1:0] w_load, w_count, w_cnt_rd;
   logic [31:0]                            w_rdata, r_rdata;
   logic                                   r_ready;
   logic                                   w_unused;

   assign w_unused = &{1'b0, io_address[1:0]};
   assign w_wr     = io_addr_strobe & io_write_strobe;
   assign w_ch_reg = (io_address[11:8] == 4'h0);
   assign w_glb    = (io_address[11:8] == 4'h1);
   assign w_pre_we = w_wr & w_glb & (io_address[7:2] == 6'd0);
   assign w_tick   = (r_pcnt == r_pre);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre  <= '0;
         r_pcnt <= '0;
      end else if (w_pre_we) begin
         r_pcnt <= '0;
         for (int k = 0; k < PRESCALE_BITS; k++)
            if (io_byte_enable[k/8]) r_pre[k] <= io_write_data[k];
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

`ifdef TIMER_IOM_SNAPSHOT_EN
   logic                                   r_snap_act, w_snap_we;
   logic [TIMER_COUNT-1:0][COUNT_BITS-1:0] w_shadow;
   assign w_snap_we = w_wr & w_glb & (io_address[7:2] == 6'd2);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_snap_act <= 1'b0;
      else if (w_snap_we && io_byte_enable[0]) r_snap_act <= io_write_data[0];
   end
`endif

   for (genvar g = 0; g < TIMER_COUNT; g++) begin : g_ch
      logic w_sel;
      assign w_sel        = w_wr & w_ch_reg & (io_address[7:4] == 4'(g));
      assign w_ctrl_we[g] = w_sel & (io_address[3:2] == 2'd0);
      assign w_load_we[g] = w_sel & (io_address[3:2] == 2'd1);
      assign w_stat_we[g] = w_sel & (io_address[3:2] == 2'd3);
`ifdef TIMER_IOM_SNAPSHOT_EN
      assign w_cnt_rd[g] = r_snap_act ? w_shadow[g] : w_count[g];
`else
      assign w_cnt_rd[g] = w_count[g];
`endif
      timer_iom_ch #(.COUNT_BITS(COUNT_BITS)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_tick    (w_tick),
         .i_ctrl_we (w_ctrl_we[g]),
         .i_load_we (w_load_we[g]),
         .i_stat_we (w_stat_we[g]),
`ifdef TIMER_IOM_SNAPSHOT_EN
         .i_snap    (w_snap_we),
         .o_shadow  (w_shadow[g]),
`endif
         .i_wdata   (io_write_data),
         .i_be      (io_byte_enable),
         .o_ctrl    (w_ctrl[g]),
         .o_load    (w_load[g]),
         .o_count   (w_count[g]),
         .o_pend    (w_pend[g]),
         .o_irq     (w_irq[g])
      );
   end

   always_comb begin
      w_rdata = '0;
      if (w_ch_reg) begin
         for (int i = 0; i < TIMER_COUNT; i++) begin
            if (io_address[7:4] == 4'(i)) begin
               case (io_address[3:2])
                  2'd0:    w_rdata[2:0]            = w_ctrl[i];
                  2'd1:    w_rdata[COUNT_BITS-1:0] = w_load[i];
                  2'd2:    w_rdata[COUNT_BITS-1:0] = w_cnt_rd[i];
                  default: w_rdata[0]              = w_pend[i];
               endcase
            end
         end
      end else if (w_glb) begin
         case (io_address[7:2])
            6'd0:    w_rdata[PRESCALE_BITS-1:0] = r_pre;
            6'd1:    w_rdata[TIMER_COUNT-1:0]   = w_pend;
`ifdef TIMER_IOM_SNAPSHOT_EN
            6'd2:    w_rdata[0]                 = r_snap_act;
`endif
            default: w_rdata = '0;
         endcase
      end
   end

   // Read data is sampled from pre-edge state and held only for the ack cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ready <= io_addr_strobe;
         r_rdata <= (io_addr_strobe && io_read_strobe) ? w_rdata : 32'd0;
      end
   end

   assign io_ready     = r_ready;
   assign io_read_data = r_rdata;
   assign irq          = w_irq;
endmodule

// File: tb/tb_timer_iom.sv
// Self-checking bench for timer_iom: directed register/timing checks plus random bus traffic
// compared every cycle against a behavioural model of the timer.

module tb_timer_iom;
   localparam int TC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          io_addr_strobe = 1'b0, io_read_strobe = 1'b0, io_write_strobe = 1'b0;
   logic [11:0]   io_address = '0;
   logic [3:0]    io_byte_enable = '0;
   logic [31:0]   io_write_data = '0;
   logic [31:0]   io_read_data;
   logic          io_ready;
   logic [TC-1:0] irq;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   timer_iom dut (
      .clk             (clk),
      .rst             (rst),
      .io_addr_strobe  (io_addr_strobe),
      .io_read_strobe  (io_read_strobe),
      .io_write_strobe (io_write_strobe),
      .io_address      (io_address),
      .io_byte_enable  (io_byte_enable),
      .io_write_data   (io_write_data),
      .io_read_data    (io_read_data),
      .io_ready        (io_ready),
      .irq             (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_en [TC], m_per [TC], m_ie [TC], m_pend [TC];
   logic [31:0] m_load [TC], m_count [TC], m_shadow [TC];
   logic [15:0] m_pre, m_pcnt;
   logic        m_snap;
   logic        e_ready;
   logic [31:0] e_rdata;
   logic [TC-1:0] e_irq;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      int ch;
      ch = int'(a[7:4]);
      if (a[11:8] == 4'h0) begin
         if (ch >= TC) return 32'd0;
         case (a[3:2])
            2'd0:    return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
            2'd1:    return m_load[ch];
            2'd2:    return m_snap ? m_shadow[ch] : m_count[ch];
            default: return {31'd0, m_pend[ch]};
         endcase
      end
      if (a[11:8] == 4'h1) begin
         if (a[7:2] == 6'd0) return {16'd0, m_pre};
         if (a[7:2] == 6'd1) return {28'd0, m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
         if (a[7:2] == 6'd2) return {31'd0, m_snap};
      end
      return 32'd0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TC; i++) begin
            m_en[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
            m_load[i] = 0; m_count[i] = 0; m_shadow[i] = 0;
         end
         m_pre = 0; m_pcnt = 0; m_snap = 0;
         e_ready = 0; e_rdata = 0; e_irq = 0;
      end else begin : step
         logic        tick, wr, expd, old_en;
         logic [11:0] a;
         logic [31:0] d, old_cnt;
         logic [3:0]  be;
         e_ready = io_addr_strobe;
         e_rdata = (io_addr_strobe && io_read_strobe) ? m_read(io_address) : 32'd0;
         for (int i = 0; i < TC; i++) e_irq[i] = m_pend[i] & m_ie[i];
         tick = (m_pcnt == m_pre);
         wr   = io_addr_strobe & io_write_strobe;
         a    = io_address & 12'hFFC;
         d    = io_write_data;
         be   = io_byte_enable;
         for (int i = 0; i < TC; i++) begin
            old_cnt = m_count[i];
            old_en  = m_en[i];
            expd    = old_en && tick && (old_cnt == 0);
            if (old_en && tick) begin
               if (old_cnt != 0) m_count[i] = old_cnt - 1;
               else if (m_per[i]) m_count[i] = m_load[i];
               else begin m_count[i] = 0; m_en[i] = 0; end
            end
            if (wr && a == 12'(i*16) && be[0]) begin
               if (d[0] && !old_en) begin m_en[i] = 1; m_count[i] = m_load[i]; end
               else if (!d[0])      begin m_en[i] = 0; m_count[i] = old_cnt; end
               else                 m_en[i] = 1;
               m_per[i] = d[1];
               m_ie[i]  = d[2];
            end
            if (expd) m_pend[i] = 1;
            else if (wr && a == 12'(i*16+12) && be[0] && d[0]) m_pend[i] = 0;
            if (wr && a == 12'(i*16+4)) m_load[i] = merge(m_load[i], d, be);
`ifdef TIMER_IOM_SNAPSHOT_EN
            if (wr && a == 12'h108) m_shadow[i] = old_cnt;
`endif
         end
         if (wr && a == 12'h100) begin
            m_pre  = 16'(merge({16'd0, m_pre}, d, be));
            m_pcnt = 0;
         end else if (tick) m_pcnt = 0;
         else m_pcnt = m_pcnt + 1;
`ifdef TIMER_IOM_SNAPSHOT_EN
         if (wr && a == 12'h108 && be[0]) m_snap = d[0];
`endif
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("io_ready", {31'd0, io_ready}, {31'd0, e_ready});
      chk("io_read_data", io_read_data, e_rdata);
      chk("irq", 32'(irq), 32'(e_irq));
   end

   // ---------------- stimulus ----------------
   task automatic idle_bus();
      io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
   endtask

   task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
      io_addr_strobe = 1; io_write_strobe = 1; io_read_strobe = 0;
      io_address = a; io_write_data = d; io_byte_enable = be;
      @(posedge clk); #1;
      idle_bus();
   endtask

   task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
      io_addr_strobe = 1; io_read_strobe = 1; io_write_strobe = 0;
      io_address = a; io_byte_enable = $urandom_range(0, 15);
      @(posedge clk); #1;
      idle_bus();
      d = io_read_data;
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_rise(input int ch, input int bound, output int t);
      logic prev;
      t = -1;
      prev = irq[ch];
      for (int c = 0; c < bound; c++) begin
         @(posedge clk); #1;
         if (irq[ch] && !prev) begin t = cyc; break; end
         prev = irq[ch];
      end
      if (t < 0) chk("irq_rise_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, d2;
      int t0, t1;
      bit found;
      idle_bus();
      rst = 1;
      tick_n(3);
      rst = 0;
      tick_n(1);

      // Reset state of every register
      for (int i = 0; i < TC; i++)
         for (int r = 0; r < 4; r++) begin
            bus_rd(12'(i*16 + r*4), d);
            chk("reset_reg", d, 32'd0);
         end
      bus_rd(12'h100, d); chk("reset_prescale", d, 32'd0);
      bus_rd(12'h104, d); chk("reset_irq_status", d, 32'd0);
      bus_rd(12'h108, d); chk("reset_snap", d, 32'd0);

      // Periodic ch0, PRESCALE=0, LOAD=9: PEND every 10 clk
      bus_wr(12'h004, 32'd9, 4'hF);
      bus_wr(12'h000, 32'd7, 4'hF);
      wait_rise(0, 40, t0);
      bus_wr(12'h00C, 32'd1, 4'hF);
      chk("irq_still_high_after_w1c", 32'(irq[0]), 32'd1);
      tick_n(1);
      chk("irq_dropped_after_w1c", 32'(irq[0]), 32'd0);
      wait_rise(0, 40, t1);
      chk("periodic_interval", 32'(t1 - t0), 32'd10);
      bus_wr(12'h000, 32'd0, 4'hF);
      bus_wr(12'h00C, 32'd1, 4'hF);

      // One-shot ch1, PRESCALE=3, LOAD=4: 20 clk to expiry
      bus_wr(12'h100, 32'd3, 4'hF);
      bus_wr(12'h014, 32'd4, 4'hF);
      bus_wr(12'h010, 32'd1, 4'hF);
      tick_n(5);
      bus_rd(12'h01C, d); chk("oneshot_not_yet", d, 32'd0);
      tick_n(25);
      bus_rd(12'h01C, d); chk("oneshot_pend", d, 32'd1);
      bus_rd(12'h010, d); chk("oneshot_ctrl_cleared", d, 32'd0);
      bus_rd(12'h018, d); chk("oneshot_count_zero", d, 32'd0);
      bus_wr(12'h01C, 32'd1, 4'hF);
      tick_n(40);
      bus_rd(12'h01C, d); chk("oneshot_no_repend", d, 32'd0);
      bus_wr(12'h100, 32'd0, 4'hF);

      // ch2 expiry in the same cycle as a W1C: set wins
      bus_wr(12'h024, 32'd5, 4'hF);
      bus_wr(12'h020, 32'd3, 4'hF);
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (m_en[2] && m_count[2] == 0) begin found = 1; break; end
         tick_n(1);
      end
      chk("sync_to_expiry", 32'(found), 32'd1);
      bus_wr(12'h02C, 32'd1, 4'hF);
      bus_rd(12'h02C, d); chk("w1c_vs_expiry_pend", d, 32'd1);
      bus_wr(12'h020, 32'd0, 4'hF);
      bus_wr(12'h02C, 32'd1, 4'hF);

      // Byte enables and unmapped space
      bus_wr(12'h024, 32'hFFFF_FFFF, 4'h1);
      bus_rd(12'h024, d); chk("load_byte_lane0", d, 32'h0000_00FF);
      bus_wr(12'h024, 32'h1234_5678, 4'hA);
      bus_rd(12'h024, d); chk("load_byte_lanes13", d, 32'h1200_56FF);
      bus_wr(12'h020, 32'd7, 4'hE);
      bus_rd(12'h020, d); chk("ctrl_lane0_off", d, 32'd0);
      bus_wr(12'h044, 32'hDEAD_BEEF, 4'hF);
      bus_rd(12'h044, d); chk("out_of_range_channel", d, 32'd0);
      bus_rd(12'h200, d); chk("unmapped", d, 32'd0);

      // Reset mid-count with irq asserted on all channels
      for (int i = 0; i < TC; i++) begin
         bus_wr(12'(i*16 + 4), 32'd2, 4'hF);
         bus_wr(12'(i*16), 32'd7, 4'hF);
      end
      tick_n(10);
      chk("all_irq_high", 32'(irq), 32'hF);
      rst = 1;
      #1;
      chk("irq_cleared_in_reset", 32'(irq), 32'd0);
      chk("ready_cleared_in_reset", 32'(io_ready), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      tick_n(2);
      for (int i = 0; i < TC; i++) begin
         bus_rd(12'(i*16), d);     chk("post_reset_ctrl", d, 32'd0);
         bus_rd(12'(i*16 + 8), d); chk("post_reset_count", d, 32'd0);
      end
      tick_n(30);
      chk("post_reset_irq_idle", 32'(irq), 32'd0);

`ifdef TIMER_IOM_SNAPSHOT_EN
      bus_wr(12'h004, 32'd1000, 4'hF);
      bus_wr(12'h000, 32'd1, 4'hF);
      tick_n(5);
      bus_wr(12'h108, 32'd1, 4'hF);
      bus_rd(12'h008, d);
      tick_n(50);
      bus_rd(12'h008, d2);
      chk("snap_frozen", d2, d);
      bus_rd(12'h108, d); chk("snap_active", d, 32'd1);
      bus_wr(12'h108, 32'd0, 4'hF);
      bus_rd(12'h008, d);
      tick_n(10);
      bus_rd(12'h008, d2);
      chk("snap_live_decrement", d - d2, 32'd11);
      bus_wr(12'h000, 32'd0, 4'hF);
`else
      bus_wr(12'h108, 32'd1, 4'hF);
      bus_rd(12'h108, d); chk("snap_absent_reads_zero", d, 32'd0);
`endif

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         int sel, ch, rg;
         logic [11:0] a;
         logic [31:0] wd;
         logic [3:0] be;
         sel = $urandom_range(0, 19);
         ch  = $urandom_range(0, TC);
         rg  = $urandom_range(0, 3);
         if (sel < 16) a = 12'(ch*16 + rg*4);
         else if (sel == 16) a = 12'h100;
         else if (sel == 17) a = 12'h104;
         else if (sel == 18) a = 12'h108;
         else a = 12'($urandom_range(0, 4095));
         be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         case (rg)
            0:       wd = $urandom_range(0, 7);
            1:       wd = $urandom_range(0, 20);
            default: wd = $urandom;
         endcase
         if (a == 12'h100) wd = $urandom_range(0, 3);
         if (a == 12'h108) wd = $urandom_range(0, 1);
         if ($urandom_range(0, 1) == 0) bus_wr(a, wd, be);
         else bus_rd(a, d);
         tick_n($urandom_range(0, 4));
      end
      tick_n(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
